periph_demux_tracker: RTL



---
 rtl/periph_demux_tracker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/periph_demux_tracker.sv
// periph_demux_tracker: routes one core-data-style master to NUM_SLV
// peripheral slaves by 2^WIN_BITS-byte address window. It tracks outstanding
// transactions so responses return in order. A new target is only accepted
// once the previous target has drained.
//
// Optional feature macro: PERIPH_DEMUX_ERR_RESP_EN
//   defined   - unmapped windows are answered by an internal error responder
//               (opc=1, rdata=0xBADACCE5) one cycle after the grant.
//   undefined - unmapped windows are routed to slave NUM_SLV-1.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   m_req_i .. m_be_i      master request channel
//   m_gnt_o                same-cycle grant (combinational)
//   m_r_valid_o/rdata/opc  in-order response (combinational from slaves)
//   s_req_o                one-hot per-slave request
//   s_add_o .. s_be_o      broadcast copies of the master fields
//   s_gnt_i                per-slave grant
//   s_r_valid_i/rdata/opc  per-slave response
module periph_demux_tracker #(
  parameter int unsigned NUM_SLV         = 11,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WIN_BITS        = 10,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                m_req_i,
  input  logic [ADDR_WIDTH-1:0]               m_add_i,
  input  logic                                m_we_i,
  input  logic [DATA_WIDTH-1:0]               m_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]             m_be_i,
  output logic                                m_gnt_o,
  output logic                                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]               m_r_rdata_o,
  output logic                                m_r_opc_o,
  output logic [NUM_SLV-1:0]                  s_req_o,
  output logic [ADDR_WIDTH-1:0]               s_add_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH-1:0]               s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             s_be_o,
  input  logic [NUM_SLV-1:0]                  s_gnt_i,
  input  logic [NUM_SLV-1:0]                  s_r_valid_i,
  input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]  s_r_rdata_i,
  input  logic [NUM_SLV-1:0]                  s_r_opc_i
);

  localparam int unsigned IDX_W = ($clog2(NUM_SLV + 1) > 1) ? $clog2(NUM_SLV + 1) : 1;
  localparam int unsigned CNT_W = ($clog2(MAX_OUTSTANDING + 1) > 1) ? $clog2(MAX_OUTSTANDING + 1) : 1;

`ifdef PERIPH_DEMUX_ERR_RESP_EN
  // Error id sits just past the last real slave, so it can never alias one.
  localparam logic [IDX_W-1:0]      ERR_ID   = IDX_W'(NUM_SLV);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);
  logic err_pend_q, err_pend_d;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cur_tgt_q, cur_tgt_d;
  logic [IDX_W-1:0] raw_idx, tgt;
  logic             unmapped, accept, xfer;
  logic             rsp_valid, rsp_opc;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Broadcast request fields; only s_req_o is steered.
  assign s_add_o   = m_add_i;
  assign s_we_o    = m_we_i;
  assign s_wdata_o = m_wdata_i;
  assign s_be_o    = m_be_i;

  // Address decode to an effective target id.
  assign raw_idx  = m_add_i[WIN_BITS +: IDX_W];
  assign unmapped = (raw_idx >= IDX_W'(NUM_SLV));
`ifdef PERIPH_DEMUX_ERR_RESP_EN
  assign tgt = unmapped ? ERR_ID : raw_idx;
`else
  assign tgt = unmapped ? IDX_W'(NUM_SLV - 1) : raw_idx;
`endif

  // Only one target may have traffic in flight, which keeps responses ordered.
  assign accept = m_req_i && (cnt_q < CNT_W'(MAX_OUTSTANDING)) &&
                  ((cnt_q == '0) || (tgt == cur_tgt_q));

  // Request steering and same-cycle grant.
  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (accept) begin
`ifdef PERIPH_DEMUX_ERR_RESP_EN
      if (unmapped) m_gnt_o = 1'b1;
`endif
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
        if (tgt == IDX_W'(i)) begin
          s_req_o[i] = 1'b1;
          m_gnt_o    = s_gnt_i[i];
        end
      end
    end
  end

  assign xfer = m_req_i && m_gnt_o;

  // Response mux from the current target; data/opc forced to 0 when idle.
  always_comb begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_opc   = 1'b0;
    if (cnt_q != '0) begin
`ifdef PERIPH_DEMUX_ERR_RESP_EN
      if (cur_tgt_q == ERR_ID) begin
        rsp_valid = err_pend_q;
        rsp_data  = ERR_DATA;
        rsp_opc   = 1'b1;
      end
`endif
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
        if (cur_tgt_q == IDX_W'(i)) begin
          rsp_valid = s_r_valid_i[i];
          rsp_data  = s_r_rdata_i[i];
          rsp_opc   = s_r_opc_i[i];
        end
      end
    end
    m_r_valid_o = rsp_valid;
    m_r_rdata_o = rsp_valid ? rsp_data : '0;
    m_r_opc_o   = rsp_valid ? rsp_opc : 1'b0;
  end

  // Next-state: outstanding counter and current target.
  always_comb begin
    cnt_d     = cnt_q;
    cur_tgt_d = cur_tgt_q;
    if (xfer) cur_tgt_d = tgt;
    case ({xfer, rsp_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef PERIPH_DEMUX_ERR_RESP_EN
  // At most one transfer per cycle, so a single pending bit suffices.
  assign err_pend_d = xfer && unmapped;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      cur_tgt_q  <= '0;
`ifdef PERIPH_DEMUX_ERR_RESP_EN
      err_pend_q <= 1'b0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      cur_tgt_q  <= cur_tgt_d;
`ifdef PERIPH_DEMUX_ERR_RESP_EN
      err_pend_q <= err_pend_d;
`endif
    end
  end

`ifndef SYNTHESIS
  // Protocol monitors: responses with nothing outstanding are tolerated
  // (e.g. late answers after reset); responses from a non-current slave are not.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (cnt_q == '0) begin
        assert (s_r_valid_i == '0)
          else $warning("periph_demux_tracker: response with no outstanding transaction ignored");
      end else begin
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
          if (cur_tgt_q != IDX_W'(i)) begin
            assert (!s_r_valid_i[i])
              else $error("periph_demux_tracker: r_valid from non-current slave %0d", i);
          end
        end
      end
    end
  end
`endif

endmodule
